// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: forward-select
// encodings, controller FSM states, register-address type and the bundle
// of stall/flush controls.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // ALU operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file read
        FWD_WB  = 2'b01,   // Writeback result
        FWD_MEM = 2'b10    // Memory-stage ALU result
    } fwd_sel_t;

    // Controller FSM states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // Pipeline hold/clear controls, packed MSB-first in output order
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

    // A later stage supplies a source operand when it writes a non-x0
    // register that matches the source.
    function automatic logic reg_match(
        input reg_addr_t rd,
        input reg_addr_t rs,
        input logic      we
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Single-operand forwarding select. Memory stage has priority over
// Writeback because it holds the younger result.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_m,
    input  logic       i_we_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_we_w,
    output logic [1:0] o_fwd
);

    fwd_sel_t w_sel;

    // Pick the youngest in-flight producer of this source register
    always_comb begin
        w_sel = FWD_RF;
        if (reg_match(i_rd_m, i_rs, i_we_m)) begin
            w_sel = FWD_MEM;
        end else if (reg_match(i_rd_w, i_rs, i_we_w)) begin
            w_sel = FWD_WB;
        end
    end

    assign o_fwd = w_sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock,
// branch redirect flushing, data-memory wait handling with a sticky
// timeout flag, and a saturating count of front-end stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic                 LoadE,
    input  logic                 PCSrcE,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteW,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MemTimeout,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int unsigned WAIT_W =
        (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    hz_state_t              r_state;
    hz_state_t              w_state_nxt;
    logic                   r_redirect_pend;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [WAIT_W-1:0]      w_wait_nxt;
    logic                   r_timeout;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;

    logic                   w_mem_stall;
    logic                   w_lw_stall;
    logic                   w_redirect;
    hz_ctrl_t               w_ctrl;

    // RegWriteE is carried for interface compatibility; the load-use
    // interlock keys only on LoadE.
    logic                   w_unused;
    assign w_unused = RegWriteE;

    // ---------------------------------------------------------------
    // Forwarding: purely combinational, independent of FSM state
    // ---------------------------------------------------------------
    fwd_unit u_fwd_a (
        .i_rs   (Rs1E),
        .i_rd_m (RdM),
        .i_we_m (RegWriteM),
        .i_rd_w (RdW),
        .i_we_w (RegWriteW),
        .o_fwd  (ForwardAE)
    );

    fwd_unit u_fwd_b (
        .i_rs   (Rs2E),
        .i_rd_m (RdM),
        .i_we_m (RegWriteM),
        .i_rd_w (RdW),
        .i_we_w (RegWriteW),
        .o_fwd  (ForwardBE)
    );

    // ---------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------
    assign w_mem_stall = MemReqM && !MemReadyM;
    assign w_lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // A branch that arrived while memory held the pipe is replayed here
    assign w_redirect  = !w_mem_stall && (PCSrcE || r_redirect_pend);

    // Stall/flush priority: memory wait, then redirect, then load-use
    always_comb begin
        w_ctrl = '0;
        if (w_mem_stall) begin
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_d = 1'b1;
            w_ctrl.stall_e = 1'b1;
            w_ctrl.stall_m = 1'b1;
        end else if (w_redirect) begin
            w_ctrl.flush_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
        end
    end

    assign StallF = w_ctrl.stall_f;
    assign StallD = w_ctrl.stall_d;
    assign StallE = w_ctrl.stall_e;
    assign StallM = w_ctrl.stall_m;
    assign FlushD = w_ctrl.flush_d;
    assign FlushE = w_ctrl.flush_e;

    // ---------------------------------------------------------------
    // Memory-wait FSM and wait counter
    // ---------------------------------------------------------------

    // Next state and wait count; the count holds at the limit to avoid wrap
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    w_state_nxt = RUN;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_wait_nxt = r_wait_cnt;
                end else begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Sticky timeout: raised on the edge where the count reaches the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if ((r_state == MEM_WAIT) && !MemReadyM && (w_wait_nxt == WAIT_LIMIT)) begin
            r_timeout <= 1'b1;
        end
    end

    assign MemTimeout = r_timeout;

    // ---------------------------------------------------------------
    // Redirect replay and stall statistics
    // ---------------------------------------------------------------

    // Remember branches seen under a memory stall; drop on first free cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_pend <= 1'b0;
        end else if (w_mem_stall) begin
            r_redirect_pend <= r_redirect_pend || PCSrcE;
        end else begin
            r_redirect_pend <= 1'b0;
        end
    end

    // Saturating count of cycles the fetch stage was held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_ctrl.stall_f && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, LoadE, PCSrcE, RegWriteM, RegWriteW;
    logic       MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemTimeout;
    logic [3:0] StallCount;

    int unsigned n_checks;
    int unsigned n_fail;

    hazard_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MemTimeout (MemTimeout),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // {StallF,StallD,StallE,StallM,FlushD,FlushE}
    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, StallF, StallD, StallE, StallM, FlushD, FlushE}, {26'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        step();
        step();

        // Reset state
        check("rst_cnt", StallCount, 0);
        check("rst_tmo", MemTimeout, 0);
        check_ctrl("rst_ctrl", 6'b000000);
        check("rst_fwda", ForwardAE, 0);
        reset = 1'b0;
        step();

        // Forwarding priority
        RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd9;
        #1;
        check("fwd_mem", ForwardAE, 2);
        check("fwd_b_rf", ForwardBE, 0);
        RegWriteM = 1'b0;
        #1;
        check("fwd_wb", ForwardAE, 1);
        RdM = 5'd0; RdW = 5'd0;
        #1;
        check("fwd_rf", ForwardAE, 0);
        RegWriteM = 1'b1; RdM = 5'd9;
        #1;
        check("fwd_b_mem", ForwardBE, 2);
        Rs1E = 5'd0; RdM = 5'd0;
        #1;
        check("fwd_x0", ForwardAE, 0);
        idle();
        step();

        // Load-use, one bubble
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        check_ctrl("lw_ctrl", 6'b110001);
        check("lw_cnt0", StallCount, 0);
        step();
        idle();
        #1;
        check_ctrl("lw_after", 6'b000000);
        check("lw_cnt1", StallCount, 1);

        // Load to x0 never interlocks
        LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        check_ctrl("lw_x0", 6'b000000);
        step();
        idle();

        // Branch beats load-use
        PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        #1;
        check_ctrl("br_lw", 6'b000011);
        step();
        idle();
        #1;
        check("br_lw_cnt", StallCount, 1);

        // Memory wait with a branch in the second stalled cycle
        MemReqM = 1'b1; MemReadyM = 1'b0;
        #1;
        check_ctrl("mw_c1", 6'b111100);
        step();
        PCSrcE = 1'b1;
        #1;
        check_ctrl("mw_c2", 6'b111100);
        step();
        PCSrcE = 1'b0;
        #1;
        check_ctrl("mw_c3", 6'b111100);
        step();
        MemReadyM = 1'b1;
        #1;
        check_ctrl("mw_redir", 6'b000011);
        check("mw_cnt", StallCount, 4);
        step();
        idle();
        #1;
        check_ctrl("mw_clear", 6'b000000);
        check("mw_no_tmo", MemTimeout, 0);

        // Timeout after four MEM_WAIT cycles, sticky afterwards
        MemReqM = 1'b1; MemReadyM = 1'b0;
        step();
        step();
        step();
        step();
        #1;
        check("tmo_3", MemTimeout, 0);
        step();
        check("tmo_4", MemTimeout, 1);
        check("tmo_cnt", StallCount, 9);
        check_ctrl("tmo_stall", 6'b111100);
        RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3;
        #1;
        check("fwd_in_wait", ForwardAE, 1);
        MemReadyM = 1'b1;
        #1;
        check_ctrl("tmo_ready", 6'b000000);
        step();
        idle();
        step();
        check("tmo_sticky", MemTimeout, 1);

        // Reset in MEM_WAIT with a pending redirect
        MemReqM = 1'b1; MemReadyM = 1'b0;
        step();
        PCSrcE = 1'b1;
        #1;
        check_ctrl("rmw_stall", 6'b111100);
        step();
        reset = 1'b1;
        #1;
        check("rmw_cnt_async", StallCount, 0);
        check("rmw_tmo_async", MemTimeout, 0);
        idle();
        #1;
        check_ctrl("rmw_in_rst", 6'b000000);
        step();
        step();
        reset = 1'b0;
        #1;
        check_ctrl("rmw_post", 6'b000000);
        check("rmw_cnt", StallCount, 0);
        step();
        check_ctrl("rmw_post2", 6'b000000);
        check("rmw_tmo", MemTimeout, 0);

        // StallCount saturates at all-ones
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat_cnt", StallCount, 15);
        idle();
        step();
        check("sat_hold", StallCount, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters: TIMEOUT_CYCLES, default 255, max data-memory wait cycles before a timeout flag; CNT_WIDTH, default 16, width of the stall counter.
REQ-002 One clock; reset is asynchronous and active-high. Ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high.
REQ-003 Rs1D, Rs2D input 5: source registers in Decode.
REQ-004 Rs1E, Rs2E, RdE input 5: registers held in the Decode/Execute pipeline register.
REQ-005 RegWriteE input 1 and LoadE input 1: the Execute instruction writes a register, or is a load.
REQ-006 PCSrcE input 1: taken branch or jump resolved in Execute.
REQ-007 RdM input 5 and RegWriteM input 1: Memory-stage destination and write enable.
REQ-008 RdW input 5 and RegWriteW input 1: Writeback-stage destination and write enable.
REQ-009 MemReqM input 1 and MemReadyM input 1: data-memory request and ready handshake in Memory.
REQ-010 StallF, StallD, StallE, StallM output 1: hold the PC and the F/D, D/E and E/M registers.
REQ-011 FlushD, FlushE output 1: FlushE drives the clear input of the Decode/Execute register.
REQ-012 ForwardAE, ForwardBE output 2: ALU operand select; 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-013 MemTimeout output 1 (sticky error flag) and StallCount output CNT_WIDTH (count of stalled cycles).

Function
REQ-014 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL follow the same rule using Rs2E.
REQ-015 Forwarding SHALL be combinational, with zero latency, in every FSM state.
REQ-016 lwStall SHALL equal LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-017 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-018 RUN to MEM_WAIT SHALL occur when MemReqM && !MemReadyM.
REQ-019 MEM_WAIT to RUN SHALL occur on the cycle MemReadyM is sampled high.
REQ-020 The FSM SHALL stay in MEM_WAIT otherwise.
REQ-021 A memory stall SHALL be asserted whenever MemReqM && !MemReadyM, in either state. During a memory stall: StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0.
REQ-022 A memory stall SHALL take priority over branch and load-use.
REQ-023 A branch seen during a memory stall SHALL set the register redirect_pend.
REQ-024 When not memory-stalled, redirect = PCSrcE || redirect_pend, and redirect SHALL drive FlushD=1 and FlushE=1.
REQ-025 redirect_pend SHALL clear on the first non-stalled cycle.
REQ-026 Redirect SHALL take priority over lwStall: with both asserted, FlushD=FlushE=1 and StallF=StallD=0.
REQ-027 With lwStall only (no redirect, no memory stall): StallF=StallD=1, FlushE=1, and all other outputs 0 — exactly one bubble.
REQ-028 The wait counter SHALL increment each cycle in MEM_WAIT and reset to 0 on entry to RUN.
REQ-029 When the wait counter reaches TIMEOUT_CYCLES, MemTimeout SHALL set to 1 and stay at 1 until reset; the stall SHALL continue.
REQ-030 StallCount SHALL increment on every cycle with StallF=1 and saturate at all-ones.

Reset
REQ-031 On reset assertion, immediately and asynchronously: FSM=RUN, redirect_pend=0, wait counter=0, MemTimeout=0, StallCount=0.
REQ-032 During reset, the combinational outputs SHALL follow the inputs; Stall*/Flush* derived from registered state SHALL read as if in RUN with no pending redirect.
REQ-033 Reset during MEM_WAIT SHALL drop any pending redirect; there SHALL be no flush after deassertion unless the inputs demand one.

Structure
REQ-034 The forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the FSM state enum SHALL live in the shared pipeline package.
REQ-035 The forwarding logic SHALL be one sub-module, fwd_unit, instantiated twice (operand A and operand B); the FSM and counters SHALL stay in hazard_ctrl.

Verification
REQ-036 Forwarding priority: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10; then set RegWriteM=0 -> ForwardAE=01; then RdM=RdW=0 -> ForwardAE=00.
REQ-037 Load-use: LoadE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 for exactly that cycle; StallCount goes 0 to 1.
REQ-038 Branch plus load-use: PCSrcE=1 and lwStall true together -> FlushD=FlushE=1, StallF=0.
REQ-039 Memory wait with branch: MemReqM=1, MemReadyM=0 for 3 cycles with PCSrcE=1 in cycle 2 -> all Stall*=1 and no flush for 3 cycles; then MemReadyM=1 -> FlushD=FlushE=1 on the next non-stalled cycle.
REQ-040 Timeout: TIMEOUT_CYCLES=4 with MemReadyM held low -> MemTimeout=1 after the 4th MEM_WAIT cycle; it stays 1 after MemReadyM=1 and clears only on reset.
REQ-041 Reset mid-wait: assert reset in MEM_WAIT with redirect_pend=1 -> after deassertion with idle inputs, all Stall*/Flush*=0 and StallCount=0.
